wb_trace_buffer: RTL

WB_TRACE_BUFFER -- requirements
Module: wb_trace_buffer

---
 rtl/wb_trace_pkg.sv | 22 ++
 rtl/wb_trace_fifo.sv | 69 ++++++
 rtl/wb_trace_buffer.sv | 133 +++++++++++++
 3 files changed

// File: rtl/wb_trace_pkg.sv
// Shared definitions for the write-back trace buffer: FSM encoding, entry layout
// and the x0 register index.
package wb_trace_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_HALTED  = 2'd2
    } state_e;

    localparam int ADDR_W       = 5;
    localparam int XLEN_DEFAULT = 32;
    localparam int ENTRY_W      = ADDR_W + XLEN_DEFAULT;

    localparam logic [ADDR_W-1:0] X0_IDX = 5'd0;

    // Entry is {addr, data}; width follows the configured XLEN.
    function automatic int entry_width(input int xlen);
        return ADDR_W + xlen;
    endfunction

endpackage

// File: rtl/wb_trace_fifo.sv
// Synchronous show-ahead FIFO for trace entries; a push into a full FIFO is
// accepted only when a pop frees a slot in the same cycle.
module wb_trace_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 37,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign full      = (count_r == FULL_CNT);
    assign empty     = (count_r == {CW{1'b0}});
    assign do_pop_s  = pop && !empty && !flush;
    assign do_push_s = push && !flush && (!full || do_pop_s);
    assign rdata     = mem_r[rd_ptr_r];
    assign count     = count_r;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1'b1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CW'(1'b1);
                2'b01:   count_r <= count_r - CW'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

endmodule

// File: rtl/wb_trace_buffer.sv
// Write-back trace buffer: captures register writes (excluding x0) into a FIFO
// under control of an IDLE/CAPTURE/HALTED FSM. Optional checker: WB_TRACE_CHECK_EN.
module wb_trace_buffer
    import wb_trace_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int XLEN  = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         wb_we,
    input  logic [4:0]                   wb_addr,
    input  logic [XLEN-1:0]              wb_data,
    input  logic                         arm,
    input  logic                         stop,
    input  logic                         clear,
    output logic                         tr_valid,
    input  logic                         tr_ready,
    output logic [4+XLEN:0]              tr_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [1:0]                   state,
    output logic                         overflow,
    input  logic [4:0]                   chk_addr,
    input  logic [XLEN-1:0]              chk_data,
    output logic                         chk_hit
);

    localparam int EW = entry_width(XLEN);
    localparam int CW = $clog2(DEPTH + 1);

    state_e state_r;
    state_e state_nx_s;
    logic   qual_s;
    logic   push_req_s;
    logic   pop_s;
    logic   drop_s;
    logic   full_s;
    logic   empty_s;
    logic   overflow_r;

    assign qual_s     = wb_we && (wb_addr != X0_IDX);
    assign push_req_s = qual_s && (state_r == ST_CAPTURE) && !clear;
    assign tr_valid   = !empty_s;
    assign pop_s      = tr_valid && tr_ready;
    assign drop_s     = push_req_s && full_s && !pop_s;
    assign state      = state_r;
    assign overflow   = overflow_r;

    wb_trace_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW),
        .CW    (CW)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (clear),
        .push  (push_req_s),
        .pop   (pop_s),
        .wdata ({wb_addr, wb_data}),
        .rdata (tr_data),
        .full  (full_s),
        .empty (empty_s),
        .count (count)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next state; stop outranks arm so a coincident arm is ignored.
    always_comb begin
        state_nx_s = state_r;
        if (clear) begin
            state_nx_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE, ST_HALTED: begin
                    if (arm && !stop) begin
                        state_nx_s = ST_CAPTURE;
                    end else begin
                        state_nx_s = state_r;
                    end
                end
                ST_CAPTURE: begin
                    if (stop || drop_s) begin
                        state_nx_s = ST_HALTED;
                    end else begin
                        state_nx_s = ST_CAPTURE;
                    end
                end
                default: state_nx_s = ST_IDLE;
            endcase
        end
    end

    // Sticky drop flag, cleared only by clear or reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow_r <= 1'b0;
        end else if (clear) begin
            overflow_r <= 1'b0;
        end else if (drop_s) begin
            overflow_r <= 1'b1;
        end
    end

`ifdef WB_TRACE_CHECK_EN
    logic chk_hit_r;

    // Sticky match of a qualified write against the expected result, any state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            chk_hit_r <= 1'b0;
        end else if (clear) begin
            chk_hit_r <= 1'b0;
        end else if (qual_s && (wb_addr == chk_addr) && (wb_data == chk_data)) begin
            chk_hit_r <= 1'b1;
        end
    end

    assign chk_hit = chk_hit_r;
`else
    logic unused_chk_s;
    assign unused_chk_s = ^{chk_addr, chk_data};
    assign chk_hit      = 1'b0;
`endif

endmodule
